// File: rtl/neurocore_result_tx_pkg.sv
// Shared constants, bit-FSM encoding and frame byte selection for the
// result transmitter. Build option: NEUROCORE_TX_PARITY_EN adds an even
// parity bit after b7 (8E1); without it the line format is 8N1.
package neurocore_result_tx_pkg;

  localparam int         CLKS_PER_BIT_DEF = 87;     // 10 MHz / 115200
  localparam logic [7:0] SYNC_BYTE_DEF    = 8'hA5;
  localparam int         FRAME_BYTES      = 3;      // sync, lo, hi

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef NEUROCORE_TX_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_e;

  // Byte idx of a frame: 0 = sync, 1 = word low, 2 = word high
  function automatic logic [7:0] frame_byte(input logic [1:0]  idx,
                                            input logic [15:0] word,
                                            input logic [7:0]  sync);
    case (idx)
      2'd0:    return sync;
      2'd1:    return word[7:0];
      default: return word[15:8];
    endcase
  endfunction

endpackage

// File: rtl/neurocore_uart_tx_byte.sv
// Bit-level UART serialiser: start, 8 data bits LSB first, optional even
// parity (NEUROCORE_TX_PARITY_EN), stop. byte_ready is high in IDLE and in
// the last cycle of the stop bit, so a new byte can follow with no gap.
module neurocore_uart_tx_byte
  import neurocore_result_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       byte_done,
  output logic       TXD
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          txd_q;
  logic          bit_end, load;
`ifdef NEUROCORE_TX_PARITY_EN
  logic          par_q;
`endif

  assign bit_end    = (cnt_q == '0);
  assign byte_done  = (state_q == TX_STOP) && bit_end;
  assign byte_ready = (state_q == TX_IDLE) || byte_done;
  assign load       = byte_valid && byte_ready;
  assign TXD        = txd_q;

  // Bit FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:   if (load) state_d = TX_START;
      TX_START:  if (bit_end) state_d = TX_DATA;
      TX_DATA:
        if (bit_end && bit_q == 3'd7) begin
`ifdef NEUROCORE_TX_PARITY_EN
          state_d = TX_PARITY;
`else
          state_d = TX_STOP;
`endif
        end
`ifdef NEUROCORE_TX_PARITY_EN
      TX_PARITY: if (bit_end) state_d = TX_STOP;
`endif
      TX_STOP:   if (bit_end) state_d = load ? TX_START : TX_IDLE;
      default:   state_d = TX_IDLE;
    endcase
  end

  // Bit FSM state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= TX_IDLE;
    else        state_q <= state_d;
  end

  // Baud counter, shifter and registered line; the counter reloads at every bit boundary
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '0;
      txd_q <= 1'b1;
`ifdef NEUROCORE_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else if (load) begin
      cnt_q <= CNT_MAX;
      bit_q <= '0;
      sh_q  <= byte_in;
      txd_q <= 1'b0;
`ifdef NEUROCORE_TX_PARITY_EN
      par_q <= ^byte_in;
`endif
    end else if (state_q != TX_IDLE) begin
      if (!bit_end) begin
        cnt_q <= cnt_q - CW'(1);
      end else begin
        cnt_q <= CNT_MAX;
        case (state_q)
          TX_START: begin
            txd_q <= sh_q[0];
            sh_q  <= {1'b0, sh_q[7:1]};
          end
          TX_DATA: begin
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef NEUROCORE_TX_PARITY_EN
              txd_q <= par_q;
`else
              txd_q <= 1'b1;
`endif
            end else begin
              txd_q <= sh_q[0];
              sh_q  <= {1'b0, sh_q[7:1]};
            end
          end
`ifdef NEUROCORE_TX_PARITY_EN
          TX_PARITY: txd_q <= 1'b1;
`endif
          TX_STOP: begin
            txd_q <= 1'b1;
            cnt_q <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/neurocore_result_tx.sv
// Result word transmitter: latches a 16-bit word on accept and sends it as
// a 3-byte frame (SYNC_BYTE, lo, hi) through the byte serialiser.
// Build option: NEUROCORE_TX_PARITY_EN (8E1 instead of 8N1).
module neurocore_result_tx
  import neurocore_result_tx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        TXD,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [1:0] IDX_LAST = 2'(FRAME_BYTES - 1);

  logic [15:0] data_q;
  logic [1:0]  idx_q;
  logic        busy_q, ready_q, done_q;
  logic        accept, byte_valid, byte_ready, byte_done;
  logic [7:0]  byte_in;

  assign accept     = word_valid && ready_q;
  // Sync byte is loaded on accept; later bytes chain on the stop-bit boundary
  assign byte_valid = accept || (busy_q && byte_done && idx_q != IDX_LAST);
  assign byte_in    = busy_q ? frame_byte(idx_q + 2'd1, data_q, SYNC_BYTE) : SYNC_BYTE;

  assign word_ready = ready_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  // Word latch, byte index and frame-level handshake
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        data_q  <= word_data;
        idx_q   <= '0;
        busy_q  <= 1'b1;
        ready_q <= 1'b0;
      end else if (busy_q && byte_done) begin
        if (idx_q == IDX_LAST) begin
          idx_q   <= '0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          done_q  <= 1'b1;
        end else begin
          idx_q <= idx_q + 2'd1;
        end
      end
    end
  end

  neurocore_uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .CLK        (CLK),
    .RESET      (RESET),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_done  (byte_done),
    .TXD        (TXD)
  );

endmodule
